// File: rtl/debug_pkg.sv
// Shared types and constants for the multi-hart debug halt/resume controller.
//   hart_state_e        per-hart handshake state
//   DEFAULT_ACK_TIMEOUT default number of cycles to wait for a hart acknowledge
package debug_pkg;

  typedef enum logic [1:0] {
    RUNNING    = 2'd0,
    HALT_REQ   = 2'd1,
    HALTED     = 2'd2,
    RESUME_REQ = 2'd3
  } hart_state_e;

  localparam int DEFAULT_ACK_TIMEOUT = 200;

endpackage

// File: rtl/debug_hart_fsm.sv
// One hart's halt/resume handshake: state register, ack timeout counter,
// sticky resumeack and sticky timeout error.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   sel_i          this hart is currently selected
//   haltreq_i      level halt request (global, qualified here by sel_i)
//   resumereq_i    one-cycle resume pulse (global, qualified by sel_i)
//   err_clr_i      clear sticky timeout error
//   dbg_mode_i     hart reports it is in debug mode
//   dbg_irq_o      debug interrupt to the hart (state HALT_REQ)
//   resume_o       resume request to the hart (state RESUME_REQ)
//   resumeack_o    sticky: last resume request was acknowledged
//   tmo_err_o      sticky: an acknowledge timed out
//   state_o        current handshake state (status reduction and debug)
//
// Handshake: the controller raises dbg_irq_o/resume_o the cycle after the
// request is sampled and holds it until the hart answers through dbg_mode_i
// (1 = entered debug, 0 = left debug); the output drops the cycle after.
module debug_hart_fsm
  import debug_pkg::*;
#(
  parameter int TMO_W       = 8,
  parameter int ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        sel_i,
  input  logic        haltreq_i,
  input  logic        resumereq_i,
  input  logic        err_clr_i,
  input  logic        dbg_mode_i,
  output logic        dbg_irq_o,
  output logic        resume_o,
  output logic        resumeack_o,
  output logic        tmo_err_o,
  output hart_state_e state_o
);

  hart_state_e      r_state;
  logic [TMO_W-1:0] r_cnt;
  logic             r_resumeack;
  logic             r_tmo_err;

  hart_state_e w_next;
  logic        w_halt_req;
  logic        w_resume_req;
  logic        w_tmo_hit;
  logic        w_set_tmo;
  logic        w_set_ack;
  logic        w_clr_ack;

  assign w_halt_req   = sel_i & haltreq_i;
  // A simultaneous halt request wins; the resume pulse is simply lost.
  assign w_resume_req = sel_i & resumereq_i & ~w_halt_req;
  assign w_tmo_hit    = (r_cnt == TMO_W'(ACK_TIMEOUT - 1));

  always_comb begin
    w_next    = r_state;
    w_set_tmo = 1'b0;
    w_set_ack = 1'b0;
    w_clr_ack = 1'b0;
    case (r_state)
      RUNNING: begin
        if (w_halt_req)      w_next = HALT_REQ;
        else if (dbg_mode_i) w_next = HALTED;    // ebreak / single-step entry
      end
      HALT_REQ: begin
        if (dbg_mode_i)      w_next = HALTED;
        else if (!w_halt_req) w_next = RUNNING;  // request withdrawn before ack
        else if (w_tmo_hit) begin
          w_next    = RUNNING;
          w_set_tmo = 1'b1;
        end
      end
      HALTED: begin
        if (w_resume_req) begin
          w_next    = RESUME_REQ;
          w_clr_ack = 1'b1;
        end else if (!dbg_mode_i) begin
          w_next = RUNNING;
        end
      end
      RESUME_REQ: begin
        if (!dbg_mode_i) begin
          w_next    = RUNNING;
          w_set_ack = 1'b1;
        end else if (w_tmo_hit) begin
          w_next    = HALTED;
          w_set_tmo = 1'b1;
        end
      end
      default: w_next = RUNNING;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= RUNNING;
      r_cnt       <= '0;
      r_resumeack <= 1'b0;
      r_tmo_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      // Counter restarts on every state change and saturates while waiting.
      if (w_next != r_state)
        r_cnt <= '0;
      else if (((r_state == HALT_REQ) || (r_state == RESUME_REQ)) && (r_cnt != '1))
        r_cnt <= r_cnt + 1'b1;
      if (w_set_ack)      r_resumeack <= 1'b1;
      else if (w_clr_ack) r_resumeack <= 1'b0;
      // A new timeout in the same cycle as a clear stays visible.
      if (w_set_tmo)      r_tmo_err <= 1'b1;
      else if (err_clr_i) r_tmo_err <= 1'b0;
    end
  end

  assign dbg_irq_o   = (r_state == HALT_REQ);
  assign resume_o    = (r_state == RESUME_REQ);
  assign resumeack_o = r_resumeack;
  assign tmo_err_o   = r_tmo_err;
  assign state_o     = r_state;

endmodule

// File: rtl/debug_hart_ctrl.sv
// Multi-hart halt/resume controller between the debug-module register file
// and HART_NUM cores. Decodes hart selection (hartsel plus hart-array
// window), runs one debug_hart_fsm per hart and reduces per-hart state into
// dmstatus-style any/all flags.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   hartsel_i           selected hart index
//   hasel_i/hawindow_i  additionally select the harts set in the window mask
//   haltreq_i           level halt request to selected harts
//   resumereq_i         one-cycle resume pulse to selected harts
//   err_clr_i           clear all sticky timeout errors
//   dbg_mode_i          per-hart debug-mode acknowledge
//   dbg_irq_o/resume_o  per-hart halt / resume requests
//   any*/all*_o         status over the selected harts
//   nonexistent_o       hartsel_i names no existing hart
//   tmo_err_o           per-hart sticky timeout flags
module debug_hart_ctrl
  import debug_pkg::*;
#(
  parameter int HART_NUM    = 4,
  parameter int HART_ID_W   = 2,
  parameter int TMO_W       = 8,
  parameter int ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [HART_ID_W-1:0] hartsel_i,
  input  logic                 hasel_i,
  input  logic [HART_NUM-1:0]  hawindow_i,
  input  logic                 haltreq_i,
  input  logic                 resumereq_i,
  input  logic                 err_clr_i,
  input  logic [HART_NUM-1:0]  dbg_mode_i,
  output logic [HART_NUM-1:0]  dbg_irq_o,
  output logic [HART_NUM-1:0]  resume_o,
  output logic                 anyhalted_o,
  output logic                 allhalted_o,
  output logic                 anyrunning_o,
  output logic                 allrunning_o,
  output logic                 anyresumeack_o,
  output logic                 allresumeack_o,
  output logic                 nonexistent_o,
  output logic [HART_NUM-1:0]  tmo_err_o
);

  logic [HART_NUM-1:0] w_sel;
  logic [HART_NUM-1:0] w_halted;
  logic [HART_NUM-1:0] w_running;
  logic [HART_NUM-1:0] w_resumeack;
  hart_state_e         w_state [HART_NUM];
  logic                w_any_sel;
  logic                w_en;

  for (genvar h = 0; h < HART_NUM; h++) begin : g_hart
    // Out-of-range hartsel values never match any h, so they select nothing.
    assign w_sel[h] = (hartsel_i == HART_ID_W'(h)) | (hasel_i & hawindow_i[h]);

    debug_hart_fsm #(
      .TMO_W       (TMO_W),
      .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_fsm (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .sel_i       (w_sel[h]),
      .haltreq_i   (haltreq_i),
      .resumereq_i (resumereq_i),
      .err_clr_i   (err_clr_i),
      .dbg_mode_i  (dbg_mode_i[h]),
      .dbg_irq_o   (dbg_irq_o[h]),
      .resume_o    (resume_o[h]),
      .resumeack_o (w_resumeack[h]),
      .tmo_err_o   (tmo_err_o[h]),
      .state_o     (w_state[h])
    );

    assign w_halted[h]  = (w_state[h] == HALTED);
    assign w_running[h] = (w_state[h] == RUNNING);
  end

  // Status flags read as 0 while reset is asserted.
  assign w_en      = ~rst_i;
  assign w_any_sel = |w_sel;

  assign anyhalted_o    = w_en & |(w_sel & w_halted);
  assign allhalted_o    = w_en & w_any_sel & ((w_sel & ~w_halted) == '0);
  assign anyrunning_o   = w_en & |(w_sel & w_running);
  assign allrunning_o   = w_en & w_any_sel & ((w_sel & ~w_running) == '0);
  assign anyresumeack_o = w_en & |(w_sel & w_resumeack);
  assign allresumeack_o = w_en & w_any_sel & ((w_sel & ~w_resumeack) == '0);
  assign nonexistent_o  = w_en & ({1'b0, hartsel_i} >= (HART_ID_W + 1)'(HART_NUM));

endmodule

// File: tb/tb_debug_hart_ctrl.sv
// Bench for debug_hart_ctrl: a 4-hart instance for the main scenarios and a
// 3-hart instance for the nonexistent-hart case.
module tb_debug_hart_ctrl;

  logic       clk;
  logic       rst;
  logic [1:0] hartsel;
  logic       hasel;
  logic [3:0] hawindow;
  logic       haltreq;
  logic       resumereq;
  logic       err_clr;
  logic [3:0] dbg_mode;
  logic [3:0] dbg_irq;
  logic [3:0] resume;
  logic       anyh, allh, anyr, allr, anyack, allack, nonex;
  logic [3:0] tmo_err;

  logic [1:0] b_hartsel;
  logic       b_haltreq;
  logic [2:0] b_dbg_mode;
  logic [2:0] b_dbg_irq;
  logic [2:0] b_resume;
  logic       b_anyh, b_allh, b_anyr, b_allr, b_anyack, b_allack, b_nonex;
  logic [2:0] b_tmo_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [11:0] exp_q[$];

  typedef struct {
    logic [1:0] hs;
    logic       hasel;
    logic [3:0] win;
    logic [3:0] dm;
    logic [6:0] exp;   // {nonexistent, anyh, allh, anyr, allr, anyack, allack}
  } vec_t;

  vec_t vecs[6];

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  debug_hart_ctrl #(.HART_NUM(4), .HART_ID_W(2), .TMO_W(8), .ACK_TIMEOUT(200)) u_dut (
    .clk_i(clk), .rst_i(rst), .hartsel_i(hartsel), .hasel_i(hasel), .hawindow_i(hawindow),
    .haltreq_i(haltreq), .resumereq_i(resumereq), .err_clr_i(err_clr), .dbg_mode_i(dbg_mode),
    .dbg_irq_o(dbg_irq), .resume_o(resume), .anyhalted_o(anyh), .allhalted_o(allh),
    .anyrunning_o(anyr), .allrunning_o(allr), .anyresumeack_o(anyack), .allresumeack_o(allack),
    .nonexistent_o(nonex), .tmo_err_o(tmo_err)
  );

  debug_hart_ctrl #(.HART_NUM(3), .HART_ID_W(2), .TMO_W(8), .ACK_TIMEOUT(200)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .hartsel_i(b_hartsel), .hasel_i(1'b0), .hawindow_i(3'b000),
    .haltreq_i(b_haltreq), .resumereq_i(1'b0), .err_clr_i(1'b0), .dbg_mode_i(b_dbg_mode),
    .dbg_irq_o(b_dbg_irq), .resume_o(b_resume), .anyhalted_o(b_anyh), .allhalted_o(b_allh),
    .anyrunning_o(b_anyr), .allrunning_o(b_allr), .anyresumeack_o(b_anyack),
    .allresumeack_o(b_allack), .nonexistent_o(b_nonex), .tmo_err_o(b_tmo_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs change at the falling edge; outputs are checked at the next falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Scoreboard step: queue the expected {dbg_irq, resume, tmo_err}, advance, compare.
  task automatic cyc(input string name, input logic [3:0] e_irq, input logic [3:0] e_res,
                     input logic [3:0] e_tmo);
    logic [11:0] v;
    exp_q.push_back({e_irq, e_res, e_tmo});
    tick();
    v = exp_q.pop_front();
    chk({name, "_irq"}, 32'(dbg_irq), 32'(v[11:8]));
    chk({name, "_resume"}, 32'(resume), 32'(v[7:4]));
    chk({name, "_tmo"}, 32'(tmo_err), 32'(v[3:0]));
  endtask

  task automatic chk_status(input string name, input logic [6:0] exp);
    chk(name, 32'({nonex, anyh, allh, anyr, allr, anyack, allack}), 32'(exp));
  endtask

  initial begin
    vecs[0] = '{hs: 2'd0, hasel: 1'b0, win: 4'b0000, dm: 4'b0000, exp: 7'b0001100};
    vecs[1] = '{hs: 2'd1, hasel: 1'b0, win: 4'b0000, dm: 4'b0010, exp: 7'b0110000};
    vecs[2] = '{hs: 2'd0, hasel: 1'b1, win: 4'b1010, dm: 4'b0010, exp: 7'b0101000};
    vecs[3] = '{hs: 2'd2, hasel: 1'b1, win: 4'b1111, dm: 4'b1111, exp: 7'b0110000};
    vecs[4] = '{hs: 2'd3, hasel: 1'b0, win: 4'b0000, dm: 4'b0111, exp: 7'b0001100};
    vecs[5] = '{hs: 2'd2, hasel: 1'b1, win: 4'b0000, dm: 4'b0100, exp: 7'b0110000};

    rst = 1'b1; hartsel = '0; hasel = 1'b0; hawindow = '0; haltreq = 1'b0;
    resumereq = 1'b0; err_clr = 1'b0; dbg_mode = '0;
    b_hartsel = '0; b_haltreq = 1'b0; b_dbg_mode = '0;
    @(negedge clk);
    tick();
    tick();

    // Reset state
    chk("rst_irq", 32'(dbg_irq), 32'h0);
    chk("rst_resume", 32'(resume), 32'h0);
    chk("rst_tmo", 32'(tmo_err), 32'h0);
    chk_status("rst_status", 7'b0000000);
    rst = 1'b0;
    tick();
    chk_status("post_rst_status", 7'b0001100);

    // Selection / aggregation table
    for (int i = 0; i < 6; i++) begin
      hartsel = vecs[i].hs; hasel = vecs[i].hasel; hawindow = vecs[i].win; dbg_mode = vecs[i].dm;
      tick();
      chk_status($sformatf("vec%0d_status", i), vecs[i].exp);
      chk($sformatf("vec%0d_irq", i), 32'(dbg_irq), 32'h0);
    end
    hasel = 1'b0; hawindow = '0; dbg_mode = '0;
    tick();

    // 1: halt hart 2, ack after 5 cycles of dbg_irq
    hartsel = 2'd2; haltreq = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      cyc($sformatf("t1_c%0d", c), (c <= 5) ? 4'b0100 : 4'b0000, 4'b0000, 4'b0000);
      if (c == 5) dbg_mode[2] = 1'b1;
    end
    chk("t1_anyhalted", 32'(anyh), 32'd1);
    chk("t1_allhalted", 32'(allh), 32'd1);
    haltreq = 1'b0;

    // 2: resume hart 1
    dbg_mode[1] = 1'b1; hartsel = 2'd1;
    tick();
    chk_status("t2_halted", 7'b0110000);
    resumereq = 1'b1;
    cyc("t2_c1", 4'b0000, 4'b0010, 4'b0000);
    resumereq = 1'b0;
    cyc("t2_c2", 4'b0000, 4'b0010, 4'b0000);
    cyc("t2_c3", 4'b0000, 4'b0010, 4'b0000);
    dbg_mode[1] = 1'b0;
    cyc("t2_c4", 4'b0000, 4'b0000, 4'b0000);
    chk_status("t2_status", 7'b0001111);

    // 4: halt and resume together on halted hart 3
    dbg_mode[3] = 1'b1; hartsel = 2'd3;
    tick();
    haltreq = 1'b1; resumereq = 1'b1;
    cyc("t4_both", 4'b0000, 4'b0000, 4'b0000);
    chk_status("t4_status", 7'b0110000);
    haltreq = 1'b0; resumereq = 1'b0;
    cyc("t4_after", 4'b0000, 4'b0000, 4'b0000);
    chk_status("t4_status2", 7'b0110000);
    // resume to a running hart is ignored
    hartsel = 2'd0; resumereq = 1'b1;
    cyc("t4_running", 4'b0000, 4'b0000, 4'b0000);
    resumereq = 1'b0;
    chk_status("t4_run_status", 7'b0001100);

    // 3: window halt, hart 3 never acks
    dbg_mode = '0;
    tick();
    hasel = 1'b1; hawindow = 4'b1011; hartsel = 2'd0; haltreq = 1'b1;
    for (int c = 1; c <= 201; c++) begin
      cyc($sformatf("t3_c%0d", c), (c <= 3) ? 4'b1011 : (c <= 200) ? 4'b1000 : 4'b0000,
          4'b0000, (c <= 200) ? 4'b0000 : 4'b1000);
      if (c == 3) dbg_mode = 4'b0011;
    end
    haltreq = 1'b0;
    chk("t3_anyhalted", 32'(anyh), 32'd1);
    chk("t3_allhalted", 32'(allh), 32'd0);
    err_clr = 1'b1;
    cyc("t3_clr", 4'b0000, 4'b0000, 4'b0000);
    err_clr = 1'b0;

    // 6: reset during RESUME_REQ of hart 0
    hasel = 1'b0; hawindow = '0; hartsel = 2'd0;
    resumereq = 1'b1;
    cyc("t6_req", 4'b0000, 4'b0001, 4'b0000);
    resumereq = 1'b0;
    cyc("t6_hold", 4'b0000, 4'b0001, 4'b0000);
    rst = 1'b1; dbg_mode = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t6_resume", 32'(resume), 32'h0);
    chk("t6_irq", 32'(dbg_irq), 32'h0);
    chk("t6_tmo", 32'(tmo_err), 32'h0);
    chk("t6_allrunning", 32'(allr), 32'd1);

    // 5: 3-hart instance, hartsel beyond the last hart
    b_hartsel = 2'd3; b_haltreq = 1'b1;
    tick(); tick(); tick();
    chk("t5_nonexistent", 32'(b_nonex), 32'd1);
    chk("t5_irq", 32'(b_dbg_irq), 32'h0);
    chk("t5_status", 32'({b_anyh, b_allh, b_anyr, b_allr, b_anyack, b_allack}), 32'h0);
    b_hartsel = 2'd2;
    tick();
    chk("t5_last_nonexistent", 32'(b_nonex), 32'd0);
    chk("t5_last_irq", 32'(b_dbg_irq), 32'b100);
    chk("t5_last_status", 32'({b_anyh, b_allh, b_anyr, b_allr}), 32'h0);
    b_haltreq = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
